soc_system_pio_irq_master: RTL and testbench

Avalon-MM initiator that services an edge-capturing input PIO (DIP switch / push-button class) entirely in hardware. It programs the PIO interrupt mask, and on each interrupt it reads the edge-capture register, clears exactly the captured bits, and reads the live input value. It then presents {edges, data} as one event on a valid/ready stream. It sits between the PIO slave port and FPGA-side logic that must react to switch changes without HPS software involvement.

---
 rtl/soc_system_pio_irq_master.sv | 154 +++++++++++++++
 tb/tb_soc_system_pio_irq_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_irq_master.sv
// soc_system_pio_irq_master: Avalon-MM initiator that services an edge-capturing PIO and streams {edges, data} events.
// Optional feature: define PIO_IRQ_MASTER_TIMESTAMP_EN to add a free-running cycle counter and evt_timestamp output.
module soc_system_pio_irq_master #(
    parameter int DATA_W = 4,
    parameter logic [DATA_W-1:0] INIT_MASK = '1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [1:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata,
    input  logic              irq,
    input  logic              mask_wr,
    input  logic [DATA_W-1:0] mask_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_edges,
    output logic [DATA_W-1:0] evt_data,
    output logic              busy
`ifdef PIO_IRQ_MASTER_TIMESTAMP_EN
    ,
    output logic [31:0]       evt_timestamp
`endif
);

    typedef enum logic [3:0] {
        ST_INIT_MASK,
        ST_IDLE,
        ST_WR_MASK,
        ST_RD_EDGE_A,
        ST_RD_EDGE_W,
        ST_CLR_EDGE,
        ST_RD_DATA_A,
        ST_RD_DATA_W,
        ST_EMIT
    } state_t;

    state_t            state, state_d;
    logic              pend_q, go_mask;
    logic [DATA_W-1:0] mask_q;
    logic              cs_d, wn_d;
    logic [1:0]        addr_d;
    logic [31:0]       wd_d;
    logic [DATA_W-1:0] rd_bits;

    assign rd_bits = readdata[DATA_W-1:0];

    if (DATA_W < 32) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^readdata[31:DATA_W];
    end

    // Next state, plus the bus values for the cycle that follows; a mask write
    // requested in the same IDLE cycle as irq wins and uses mask_in directly.
    always_comb begin
        state_d = state;
        go_mask = 1'b0;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = 2'd0;
        wd_d    = '0;
        case (state)
            ST_INIT_MASK: state_d = ST_IDLE;
            ST_IDLE: begin
                if (pend_q || mask_wr) begin
                    state_d = ST_WR_MASK;
                    go_mask = 1'b1;
                end else if (irq) begin
                    state_d = ST_RD_EDGE_A;
                end
            end
            ST_WR_MASK:   state_d = ST_IDLE;
            ST_RD_EDGE_A: state_d = ST_RD_EDGE_W;
            ST_RD_EDGE_W: state_d = (rd_bits == '0) ? ST_IDLE : ST_CLR_EDGE;
            ST_CLR_EDGE:  state_d = ST_RD_DATA_A;
            ST_RD_DATA_A: state_d = ST_RD_DATA_W;
            ST_RD_DATA_W: state_d = ST_EMIT;
            ST_EMIT:      state_d = evt_ready ? ST_IDLE : ST_EMIT;
            default:      state_d = ST_INIT_MASK;
        endcase
        if (state == ST_INIT_MASK) begin
            cs_d = 1'b1;
            wn_d = 1'b0;
            addr_d = 2'd2;
            wd_d[DATA_W-1:0] = INIT_MASK;
        end else if (go_mask) begin
            cs_d = 1'b1;
            wn_d = 1'b0;
            addr_d = 2'd2;
            wd_d[DATA_W-1:0] = mask_wr ? mask_in : mask_q;
        end else if (state_d == ST_RD_EDGE_A) begin
            cs_d = 1'b1;
            addr_d = 2'd3;
        end else if (state_d == ST_CLR_EDGE) begin
            cs_d = 1'b1;
            wn_d = 1'b0;
            addr_d = 2'd3;
            wd_d[DATA_W-1:0] = rd_bits;
        end else if (state_d == ST_RD_DATA_A) begin
            cs_d = 1'b1;
        end
    end

    // State, registered bus/event outputs, pending mask request and captured read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT_MASK;
            address    <= 2'd0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= '0;
            evt_valid  <= 1'b0;
            evt_edges  <= '0;
            evt_data   <= '0;
            busy       <= 1'b0;
            pend_q     <= 1'b0;
            mask_q     <= INIT_MASK;
        end else begin
            state      <= state_d;
            address    <= addr_d;
            chipselect <= cs_d;
            write_n    <= wn_d;
            writedata  <= wd_d;
            evt_valid  <= (state_d == ST_EMIT);
            busy       <= (state_d != ST_IDLE);
            pend_q     <= go_mask ? 1'b0 : (pend_q | mask_wr);
            if (mask_wr)
                mask_q <= mask_in;
            if (state == ST_RD_EDGE_W)
                evt_edges <= rd_bits;
            if (state == ST_RD_DATA_W)
                evt_data <= rd_bits;
        end
    end

`ifdef PIO_IRQ_MASTER_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // Free-running cycle counter, sampled into the event when the edge read is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt        <= '0;
            evt_timestamp <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (state == ST_RD_EDGE_A)
                evt_timestamp <= ts_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_soc_system_pio_irq_master.sv
// tb_soc_system_pio_irq_master: directed bench with a small edge-capturing PIO model.
module tb_soc_system_pio_irq_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata;
    logic [31:0] rdata = '0;
    logic        irq;
    logic        mask_wr = 1'b0;
    logic [3:0]  mask_in = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [3:0]  evt_edges, evt_data;
    logic        busy;
`ifdef PIO_IRQ_MASTER_TIMESTAMP_EN
    logic [31:0] evt_timestamp;
`endif

    logic [3:0] pin = '0, pin_q = '0, cap = '0, pmask = '0;
    logic       irq_force = 1'b0;
    int         n_vec = 0, n_bad = 0;

    soc_system_pio_irq_master #(.DATA_W(4)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata), .irq(irq),
        .mask_wr(mask_wr), .mask_in(mask_in), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_edges(evt_edges), .evt_data(evt_data),
        .busy(busy)
`ifdef PIO_IRQ_MASTER_TIMESTAMP_EN
        , .evt_timestamp(evt_timestamp)
`endif
    );

    always #5 clk = ~clk;

    assign irq = |(cap & pmask) | irq_force;

    // PIO slave model: any-edge capture, write-one-to-clear, read latency 1.
    always @(posedge clk) begin
        pin_q <= pin;
        if (reset) begin
            cap   <= '0;
            pmask <= '0;
            rdata <= '0;
        end else begin
            cap <= (cap & ~((chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'd0)) | (pin ^ pin_q);
            if (chipselect && !write_n && address == 2'd2)
                pmask <= writedata[3:0];
            rdata <= (chipselect && write_n) ?
                     (address == 2'd3 ? {28'd0, cap} : address == 2'd2 ? {28'd0, pmask} : {28'd0, pin}) : 32'd0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
        check({tag, "_bus"}, {chipselect, write_n, address}, {28'd0, cs, wn, a});
        if (cs && !wn)
            check({tag, "_wd"}, writedata, wd);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!evt_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, evt_valid}, 32'd1);
    endtask

    initial begin
        int stable;
        int cs_cnt;
        int v_cnt;
        repeat (3) tick();
        check("rst_bus", {chipselect, write_n, address}, 32'b0100);
        check("rst_wd", writedata, 0);
        check("rst_evt", {evt_valid, evt_edges, evt_data, busy}, 0);
        reset = 1'b0;
        tick();
        check_bus("init_wr", 1, 0, 2'd2, 32'hF);
        check("init_busy", {31'd0, busy}, 0);
        tick();
        check_bus("init_idle", 0, 1, 2'd0, 0);
        check("init_evt", {evt_valid, evt_edges, evt_data, busy}, 0);
        repeat (2) tick();

        pin = 4'h2;
        tick();
        tick();
        check_bus("se_rd_edge", 1, 1, 2'd3, 0);
        check("se_busy", {31'd0, busy}, 1);
        tick();
        check_bus("se_wait", 0, 1, 2'd0, 0);
        tick();
        check_bus("se_clr", 1, 0, 2'd3, 32'h2);
        tick();
        check_bus("se_rd_data", 1, 1, 2'd0, 0);
        check("se_irq_low", {31'd0, irq}, 0);
        tick();
        check("se_t5_valid", {31'd0, evt_valid}, 0);
        tick();
        check("se_t6_valid", {31'd0, evt_valid}, 1);
        check("se_edges", {28'd0, evt_edges}, 32'h2);
        check("se_data", {28'd0, evt_data}, 32'h2);
        evt_ready = 1'b1;
        tick();
        check("se_accept", {30'd0, evt_valid, busy}, 0);
        evt_ready = 1'b0;
        repeat (2) tick();

        pin = 4'h3;
        wait_valid("bp_ev1");
        check("bp_ev1_edges", {28'd0, evt_edges}, 32'h1);
        check("bp_ev1_data", {28'd0, evt_data}, 32'h3);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            if (i <= 16 && i % 2 == 0)
                pin = pin ^ 4'h1;
            tick();
            if (evt_valid && evt_edges == 4'h1 && evt_data == 4'h3)
                stable++;
        end
        check("bp_stable", stable, 20);
        evt_ready = 1'b1;
        tick();
        check("bp_accept", {31'd0, evt_valid}, 0);
        wait_valid("bp_ev2");
        check("bp_ev2_edges", {28'd0, evt_edges}, 32'h1);
        check("bp_ev2_data", {28'd0, evt_data}, 32'h2);
        tick();
        check("bp_pulse", {31'd0, evt_valid}, 0);
        evt_ready = 1'b0;
        repeat (3) tick();

        pin = 4'hA;
        wait_valid("mk_ev");
        check("mk_edges", {28'd0, evt_edges}, 32'h8);
        check("mk_data", {28'd0, evt_data}, 32'hA);
        mask_wr = 1'b1;
        mask_in = 4'h1;
        tick();
        mask_wr = 1'b0;
        tick();
        check("mk_hold", {31'd0, evt_valid}, 1);
        check_bus("mk_no_wr_in_emit", 0, 1, 2'd0, 0);
        evt_ready = 1'b1;
        tick();
        check("mk_idle", {30'd0, evt_valid, chipselect}, 0);
        evt_ready = 1'b0;
        tick();
        check_bus("mk_wr", 1, 0, 2'd2, 32'h1);
        tick();
        pin = 4'h2;
        cs_cnt = 0;
        v_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cs_cnt += int'(chipselect);
            v_cnt += int'(evt_valid);
        end
        check("mk_masked_bus", cs_cnt, 0);
        check("mk_masked_evt", v_cnt, 0);
        mask_wr = 1'b1;
        mask_in = 4'hF;
        tick();
        mask_wr = 1'b0;
        evt_ready = 1'b1;
        wait_valid("mk_restore");
        check("mk_restore_edges", {28'd0, evt_edges}, 32'h8);
        check("mk_restore_data", {28'd0, evt_data}, 32'h2);
        tick();
        evt_ready = 1'b0;
        repeat (3) tick();

        irq_force = 1'b1;
        tick();
        irq_force = 1'b0;
        check_bus("sp_rd_edge", 1, 1, 2'd3, 0);
        tick();
        check_bus("sp_wait", 0, 1, 2'd0, 0);
        tick();
        check_bus("sp_no_clr", 0, 1, 2'd0, 0);
        check("sp_busy", {31'd0, busy}, 0);
        cs_cnt = 0;
        v_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cs_cnt += int'(chipselect);
            v_cnt += int'(evt_valid);
        end
        check("sp_quiet", cs_cnt + v_cnt, 0);

        pin = 4'h3;
        tick();
        repeat (3) tick();
        check_bus("mr_clr", 1, 0, 2'd3, 32'h1);
        reset = 1'b1;
        tick();
        check_bus("mr_bus", 0, 1, 2'd0, 0);
        check("mr_evt", {30'd0, evt_valid, busy}, 0);
        reset = 1'b0;
        tick();
        check_bus("mr_init_wr", 1, 0, 2'd2, 32'hF);
        tick();
        check_bus("mr_idle", 0, 1, 2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
